// File: rtl/debug_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module   : debug_cmd_engine
// Brief    : Framed serial debug command engine driving an LED bank, with
//            framed read-back on debug_do and a sticky bad-opcode flag.
// Revision : 1.0 - initial release
// ============================================================================
module debug_cmd_engine #(
    parameter int LedCount   = 4,
    parameter int ArgWidth   = 8,
    parameter int SyncStages = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                debug_clk,
    input  logic                debug_cs,
    input  logic                debug_di,
    output logic                debug_do,
    output logic [LedCount-1:0] led,
    input  logic [ArgWidth-1:0] status_in,
    output logic                cmd_err
);

    localparam int c_frame_w = 8 + ArgWidth;

    logic [SyncStages-1:0] r_clk_sync;
    logic [SyncStages-1:0] r_cs_sync;
    logic [SyncStages-1:0] r_di_sync;
    logic                  r_clk_prev;

    logic [c_frame_w-1:0]  r_sr;
    logic [ArgWidth:0]     r_resp;
    logic                  r_do;
    logic [LedCount-1:0]   r_led;
    logic                  r_err;

    logic                  w_clk;
    logic                  w_cs;
    logic                  w_di;
    logic                  w_rise;
    logic                  w_fall;
    logic                  w_exec;
    logic [6:0]            w_opcode;
    logic [ArgWidth-1:0]   w_arg;
    logic [LedCount-1:0]   w_led_arg;
    logic [ArgWidth-1:0]   w_led_zx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_sync <= '0;
            r_cs_sync  <= '0;
            r_di_sync  <= '0;
            r_clk_prev <= 1'b0;
        end else begin
            r_clk_sync <= {r_clk_sync[SyncStages-2:0], debug_clk};
            r_cs_sync  <= {r_cs_sync[SyncStages-2:0], debug_cs};
            r_di_sync  <= {r_di_sync[SyncStages-2:0], debug_di};
            r_clk_prev <= w_clk;
        end
    end

    assign w_clk     = r_clk_sync[SyncStages-1];
    assign w_cs      = r_cs_sync[SyncStages-1];
    assign w_di      = r_di_sync[SyncStages-1];
    assign w_rise    = w_clk & ~r_clk_prev;
    assign w_fall    = ~w_clk & r_clk_prev;

    // A frame is complete once its start bit reaches the top of the shifter.
    assign w_exec    = r_sr[c_frame_w-1];
    assign w_opcode  = r_sr[c_frame_w-2:ArgWidth];
    assign w_arg     = r_sr[ArgWidth-1:0];
    assign w_led_arg = w_arg[LedCount-1:0];
    assign w_led_zx  = ArgWidth'(r_led);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr   <= '0;
            r_resp <= '0;
            r_do   <= 1'b0;
            r_led  <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_fall) begin
                r_do   <= r_resp[ArgWidth];
                r_resp <= r_resp << 1;
            end

            // A new read replaces any response still being shifted out.
            if (w_exec) begin
                case (w_opcode)
                    7'h00:   r_led  <= r_led & ~w_led_arg;
                    7'h01:   r_led  <= r_led | w_led_arg;
                    7'h02:   r_led  <= w_led_arg;
                    7'h03:   r_led  <= r_led ^ w_led_arg;
                    7'h04:   r_resp <= {1'b1, w_led_zx};
                    7'h05:   r_resp <= {1'b1, status_in};
                    7'h06:   r_resp <= {1'b1, w_arg};
                    7'h7F:   begin end
                    default: r_err  <= 1'b1;
                endcase
                r_sr <= '0;
            end else if (w_rise) begin
                r_sr <= {r_sr[c_frame_w-2:0], w_di};
            end

            // Deselect discards partial frames and pending responses.
            if (!w_cs) begin
                r_sr   <= '0;
                r_resp <= '0;
                r_do   <= 1'b0;
            end
        end
    end

    assign debug_do = r_do;
    assign led      = r_led;
    assign cmd_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_debug_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_debug_cmd_engine
// Brief    : Self-checking bench for debug_cmd_engine against a command-level
//            model of the LED bank, error flag and read-back framing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debug_cmd_engine;

    localparam int c_lc = 4;
    localparam int c_aw = 8;
    localparam int c_ss = 2;
    localparam int c_fw = 8 + c_aw;

    logic            clk;
    logic            rst;
    logic            debug_clk;
    logic            debug_cs;
    logic            debug_di;
    logic            debug_do;
    logic [c_lc-1:0] led;
    logic [c_aw-1:0] status_in;
    logic            cmd_err;

    int checks;
    int failures;

    logic [c_lc-1:0] led_m;
    logic            err_m;

    debug_cmd_engine #(
        .LedCount   (c_lc),
        .ArgWidth   (c_aw),
        .SyncStages (c_ss)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .debug_clk (debug_clk),
        .debug_cs  (debug_cs),
        .debug_di  (debug_di),
        .debug_do  (debug_do),
        .led       (led),
        .status_in (status_in),
        .cmd_err   (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One host bit: debug_do is sampled just before the rising edge.
    task automatic send_bit(input logic b, output logic smp);
        @(negedge clk);
        debug_di = b;
        repeat (4) @(negedge clk);
        smp = debug_do;
        debug_clk = 1'b1;
        repeat (5) @(negedge clk);
        debug_clk = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic send_frame(input logic [6:0] op, input logic [c_aw-1:0] arg);
        logic [c_fw-1:0] fr;
        logic            s;
        fr = {1'b1, op, arg};
        for (int i = c_fw - 1; i >= 0; i--) send_bit(fr[i], s);
    endtask

    // Host view: first 1 on debug_do is the start bit, then data, then zeros.
    task automatic read_back(input logic [c_aw-1:0] exp);
        logic [11:0]     bits;
        logic            s;
        int              first;
        logic [c_aw-1:0] data;
        logic            tail;
        for (int i = 0; i < 12; i++) begin
            send_bit(1'b0, s);
            bits[i] = s;
        end
        first = -1;
        for (int i = 0; i < 12; i++) if (bits[i] && first < 0) first = i;
        check("rd_start_found", 32'(first >= 0 && first <= 12 - (c_aw + 1)), 32'd1);
        if (first >= 0 && first <= 12 - (c_aw + 1)) begin
            data = '0;
            for (int i = 0; i < c_aw; i++) data = {data[c_aw-2:0], bits[first+1+i]};
            check("rd_data", 32'(data), 32'(exp));
            tail = 1'b0;
            for (int i = first + 1 + c_aw; i < 12; i++) tail = tail | bits[i];
            check("rd_trailing_zero", 32'(tail), 32'd0);
        end
    endtask

    task automatic model_exec(input logic [6:0] op, input logic [c_aw-1:0] arg,
                              output logic is_rd, output logic [c_aw-1:0] rv);
        logic [c_lc-1:0] a;
        a     = arg[c_lc-1:0];
        is_rd = 1'b0;
        rv    = '0;
        case (op)
            7'h00: led_m = led_m & ~a;
            7'h01: led_m = led_m | a;
            7'h02: led_m = a;
            7'h03: led_m = led_m ^ a;
            7'h04: begin is_rd = 1'b1; rv = c_aw'(led_m); end
            7'h05: begin is_rd = 1'b1; rv = status_in; end
            7'h06: begin is_rd = 1'b1; rv = arg; end
            7'h7F: ;
            default: err_m = 1'b1;
        endcase
    endtask

    task automatic do_cmd(input logic [6:0] op, input logic [c_aw-1:0] arg);
        logic            is_rd;
        logic [c_aw-1:0] rv;
        model_exec(op, arg, is_rd, rv);
        send_frame(op, arg);
        check("led", 32'(led), 32'(led_m));
        check("cmd_err", 32'(cmd_err), 32'(err_m));
        if (is_rd) read_back(rv);
    endtask

    initial begin
        logic            s;
        logic [c_fw-1:0] part;
        logic [6:0]      op;
        logic [c_aw-1:0] arg;
        int              r;

        checks    = 0;
        failures  = 0;
        led_m     = '0;
        err_m     = 1'b0;
        rst       = 1'b1;
        debug_clk = 1'b0;
        debug_cs  = 1'b1;
        debug_di  = 1'b1;
        status_in = '0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            debug_clk = ~debug_clk;
        end
        check("rst_led", 32'(led), 32'd0);
        check("rst_do", 32'(debug_do), 32'd0);
        check("rst_err", 32'(cmd_err), 32'd0);
        debug_clk = 1'b0;
        debug_cs  = 1'b0;
        debug_di  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("post_rst_led", 32'(led), 32'd0);
        check("post_rst_do", 32'(debug_do), 32'd0);
        debug_cs = 1'b1;
        repeat (5) @(negedge clk);

        do_cmd(7'h01, 8'h05);
        check("set_0101", 32'(led), 32'h5);
        do_cmd(7'h03, 8'h03);
        check("toggle_0110", 32'(led), 32'h6);

        for (int i = 0; i < 5; i++) send_bit(1'b0, s);
        do_cmd(7'h02, 8'h0A);
        check("write_1010", 32'(led), 32'hA);

        status_in = 8'hA5;
        do_cmd(7'h05, 8'h00);

        part = {1'b1, 7'h01, 8'h0F};
        for (int i = c_fw - 1; i >= c_fw - 10; i--) send_bit(part[i], s);
        @(negedge clk);
        debug_cs = 1'b0;
        repeat (6) @(negedge clk);
        debug_cs = 1'b1;
        repeat (5) @(negedge clk);
        do_cmd(7'h02, 8'h01);
        check("abort_0001", 32'(led), 32'h1);

        do_cmd(7'h10, 8'hFF);
        check("unknown_err", 32'(cmd_err), 32'd1);
        check("unknown_led", 32'(led), 32'h1);

        for (int n = 0; n < 36; n++) begin
            r         = $urandom_range(0, 9);
            arg       = 8'($urandom);
            status_in = 8'($urandom);
            if (r <= 6)      op = 7'(r);
            else if (r == 7) op = 7'h7F;
            else             op = 7'($urandom_range(7, 126));
            do_cmd(op, arg);
        end

        part = {1'b1, 7'h02, 8'h0F};
        for (int i = c_fw - 1; i >= c_fw - 6; i--) send_bit(part[i], s);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_led", 32'(led), 32'd0);
        check("midrst_err", 32'(cmd_err), 32'd0);
        check("midrst_do", 32'(debug_do), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
